// File: rtl/stage3_mem_pkg.sv
// Shared definitions for the stage3 memory-access stage: FSM encoding,
// request opcodes and default widths.
package stage3_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Opcodes the fetch/decode stage uses to form memory requests
    localparam logic [7:0] OPCODE_READRAM8   = 8'd1;
    localparam logic [7:0] OPCODE_JUMPMINUS  = 8'd2;
    localparam logic [7:0] OPCODE_WRITERAM8  = 8'd3;
    localparam logic [7:0] OPCODE_READRAM16  = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // A wide access starting on an odd byte address
    function automatic logic is_misaligned(input logic wide, input logic addr_lsb);
        return wide & addr_lsb;
    endfunction

endpackage

// File: rtl/stage3_mem_if.sv
// Request/response channel between the fetch/decode stage (master) and
// the memory-access stage (slave).
interface stage3_mem_if
    import stage3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_wide;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_wide, req_address, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_wide, req_address, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/stage3_mem_seq.sv
// Byte sequencer for stage3_mem: latches the request, walks one or two
// bytes from the base address (wrapping modulo 2^ADDR_W), steers store
// bytes onto the RAM data bus and assembles load bytes little-endian.
module stage3_mem_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              accept_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wide_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              cap_i,
    input  logic              adv_i,
    input  logic              we_i,
    input  logic [7:0]        ram_rdata_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_q;
    logic              cnt_q;
    logic              wide_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        byte0_q;
    logic [7:0]        byte1_q;

    // Request latch, byte counter and load-byte capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            base_q  <= '0;
            cnt_q   <= 1'b0;
            wide_q  <= 1'b0;
            wdata_q <= '0;
            byte0_q <= 8'h00;
            byte1_q <= 8'h00;
        end else if (accept_i) begin
            base_q  <= addr_i;
            cnt_q   <= 1'b0;
            wide_q  <= wide_i;
            // upper byte is dropped for narrow stores so it can never leak out
            wdata_q <= wide_i ? wdata_i : {8'h00, wdata_i[7:0]};
            byte0_q <= 8'h00;
            byte1_q <= 8'h00;
        end else begin
            if (cap_i) begin
                if (cnt_q) byte1_q <= ram_rdata_i;
                else       byte0_q <= ram_rdata_i;
            end
            if (adv_i) cnt_q <= 1'b1;
        end
    end

    // Address holds base+counter, so it keeps its last value while idle
    assign ram_addr_o  = base_q + {{(ADDR_W-1){1'b0}}, cnt_q};
    assign ram_wdata_o = we_i ? (cnt_q ? wdata_q[15:8] : wdata_q[7:0]) : 8'h00;
    assign rdata_o     = {byte1_q, byte0_q};
    assign last_o      = ~wide_q | cnt_q;

endmodule

// File: rtl/stage3_mem.sv
// Memory-access stage: accepts one load/store per handshake, runs it as
// one or two byte accesses on a byte-wide synchronous RAM, and returns
// data or a write acknowledge on the response channel.
// Optional macro STAGE3_MEM_ALIGN_CHECK_EN: wide requests at odd addresses
// skip the RAM and respond immediately with rsp_error=1.
//
// state       | meaning
// ST_IDLE     | waiting for a request, req_ready high
// ST_RD_ISSUE | RAM address driven for the current load byte
// ST_RD_CAP   | RAM data valid, captured at end of cycle
// ST_WR_BYTE  | write enable high for the current store byte
// ST_RESP     | response held until rsp_ready
module stage3_mem
    import stage3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              ram_clk,
    input  logic              rst,
    stage3_mem_if.slave       bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enable,
    output logic [7:0]        ram_data_in,
    input  logic [7:0]        ram_data_out,
    output logic              busy
);

    state_t state_q;
    state_t state_d;
    logic   write_q;
    logic   accept;
    logic   cap;
    logic   adv;
    logic   last;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

`ifdef STAGE3_MEM_ALIGN_CHECK_EN
    logic misalign;
    logic err_q;

    assign misalign = is_misaligned(bus.req_wide, bus.req_address[0]);

    // Error flag latched per request, held through the response
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= misalign;
    end

    assign bus.rsp_error = err_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Store/load flag captured at acceptance
    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst)        write_q <= 1'b0;
        else if (accept) write_q <= bus.req_write;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.req_write) state_d = ST_WR_BYTE;
                    else               state_d = ST_RD_ISSUE;
`ifdef STAGE3_MEM_ALIGN_CHECK_EN
                    if (misalign) state_d = ST_RESP;
`endif
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_CAP;
            ST_RD_CAP:   state_d = last ? ST_RESP : ST_RD_ISSUE;
            ST_WR_BYTE:  state_d = last ? ST_RESP : ST_WR_BYTE;
            ST_RESP:     if (bus.rsp_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and sequencer controls
    always_comb begin
        bus.req_ready    = (state_q == ST_IDLE);
        bus.rsp_valid    = (state_q == ST_RESP);
        ram_write_enable = (state_q == ST_WR_BYTE);
        busy             = (state_q != ST_IDLE);
        cap              = (state_q == ST_RD_CAP);
        adv              = ((state_q == ST_RD_CAP) || (state_q == ST_WR_BYTE)) && !last;
    end

    stage3_mem_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_seq (
        .clk_i       (ram_clk),
        .rst_n_i     (rst),
        .accept_i    (accept),
        .addr_i      (bus.req_address),
        .wide_i      (bus.req_wide),
        .wdata_i     (bus.req_wdata),
        .cap_i       (cap),
        .adv_i       (adv),
        .we_i        (ram_write_enable),
        .ram_rdata_i (ram_data_out),
        .ram_addr_o  (ram_address),
        .ram_wdata_o (ram_data_in),
        .rdata_o     (bus.rsp_rdata),
        .last_o      (last)
    );

    // write_q records the access direction for the response path; loads
    // and stores are already distinguished by the FSM state they run in
    logic unused_write;
    assign unused_write = write_q;

endmodule
